// File: rtl/sha2_k_sequencer.sv
// rtl/sha2_k_sequencer.sv - SHA-2 round-constant streamer that owns the round counter
// Streams K[0..ROUNDS-1] over a registered valid/ready handshake with stall, abort and a done pulse.
module sha2_k_sequencer #(
  parameter int WORD_W = 32,
  parameter int RND_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              k_ready,
  output logic [WORD_W-1:0] k,
  output logic [RND_W-1:0]  round,
  output logic              k_valid,
  output logic              k_last,
  output logic              busy,
  output logic              done
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_k_sequencer: WORD_W must be 32 or 64");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] k_q, k_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              k_last_q, k_last_d;
  logic              done_q, done_d;

  // SHA-384/512 table; its upper halves of entries 0..63 are exactly the SHA-224/256 table.
  function automatic logic [63:0] k512(input int idx);
    logic [63:0] v;
    case (idx)
      0:  v = 64'h428a2f98d728ae22;
      1:  v = 64'h7137449123ef65cd;
      2:  v = 64'hb5c0fbcfec4d3b2f;
      3:  v = 64'he9b5dba58189dbbc;
      4:  v = 64'h3956c25bf348b538;
      5:  v = 64'h59f111f1b605d019;
      6:  v = 64'h923f82a4af194f9b;
      7:  v = 64'hab1c5ed5da6d8118;
      8:  v = 64'hd807aa98a3030242;
      9:  v = 64'h12835b0145706fbe;
      10: v = 64'h243185be4ee4b28c;
      11: v = 64'h550c7dc3d5ffb4e2;
      12: v = 64'h72be5d74f27b896f;
      13: v = 64'h80deb1fe3b1696b1;
      14: v = 64'h9bdc06a725c71235;
      15: v = 64'hc19bf174cf692694;
      16: v = 64'he49b69c19ef14ad2;
      17: v = 64'hefbe4786384f25e3;
      18: v = 64'h0fc19dc68b8cd5b5;
      19: v = 64'h240ca1cc77ac9c65;
      20: v = 64'h2de92c6f592b0275;
      21: v = 64'h4a7484aa6ea6e483;
      22: v = 64'h5cb0a9dcbd41fbd4;
      23: v = 64'h76f988da831153b5;
      24: v = 64'h983e5152ee66dfab;
      25: v = 64'ha831c66d2db43210;
      26: v = 64'hb00327c898fb213f;
      27: v = 64'hbf597fc7beef0ee4;
      28: v = 64'hc6e00bf33da88fc2;
      29: v = 64'hd5a79147930aa725;
      30: v = 64'h06ca6351e003826f;
      31: v = 64'h142929670a0e6e70;
      32: v = 64'h27b70a8546d22ffc;
      33: v = 64'h2e1b21385c26c926;
      34: v = 64'h4d2c6dfc5ac42aed;
      35: v = 64'h53380d139d95b3df;
      36: v = 64'h650a73548baf63de;
      37: v = 64'h766a0abb3c77b2a8;
      38: v = 64'h81c2c92e47edaee6;
      39: v = 64'h92722c851482353b;
      40: v = 64'ha2bfe8a14cf10364;
      41: v = 64'ha81a664bbc423001;
      42: v = 64'hc24b8b70d0f89791;
      43: v = 64'hc76c51a30654be30;
      44: v = 64'hd192e819d6ef5218;
      45: v = 64'hd69906245565a910;
      46: v = 64'hf40e35855771202a;
      47: v = 64'h106aa07032bbd1b8;
      48: v = 64'h19a4c116b8d2d0c8;
      49: v = 64'h1e376c085141ab53;
      50: v = 64'h2748774cdf8eeb99;
      51: v = 64'h34b0bcb5e19b48a8;
      52: v = 64'h391c0cb3c5c95a63;
      53: v = 64'h4ed8aa4ae3418acb;
      54: v = 64'h5b9cca4f7763e373;
      55: v = 64'h682e6ff3d6b2b8a3;
      56: v = 64'h748f82ee5defb2fc;
      57: v = 64'h78a5636f43172f60;
      58: v = 64'h84c87814a1f0ab72;
      59: v = 64'h8cc702081a6439ec;
      60: v = 64'h90befffa23631e28;
      61: v = 64'ha4506cebde82bde9;
      62: v = 64'hbef9a3f7b2c67915;
      63: v = 64'hc67178f2e372532b;
      64: v = 64'hca273eceea26619c;
      65: v = 64'hd186b8c721c0c207;
      66: v = 64'heada7dd6cde0eb1e;
      67: v = 64'hf57d4f7fee6ed178;
      68: v = 64'h06f067aa72176fba;
      69: v = 64'h0a637dc5a2c898a6;
      70: v = 64'h113f9804bef90dae;
      71: v = 64'h1b710b35131c471b;
      72: v = 64'h28db77f523047d84;
      73: v = 64'h32caab7b40c72493;
      74: v = 64'h3c9ebe0a15c9bebc;
      75: v = 64'h431d67c49c100d4c;
      76: v = 64'h4cc5d4becb3e42b6;
      77: v = 64'h597f299cfc657e2a;
      78: v = 64'h5fcb6fab3ad6faec;
      79: v = 64'h6c44198c4a475817;
      default: v = 64'h0;
    endcase
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] k_word(input int idx);
    if (idx >= ROUNDS) return '0;
    return WORD_W'(k512(idx) >> (64 - WORD_W));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      round_q  <= '0;
      k_last_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      round_q  <= round_d;
      k_last_q <= k_last_d;
      done_q   <= done_d;
    end
  end

  // abort outranks both a pending start and a simultaneous transfer
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start && !abort) state_d = S_RUN;
    end else begin
      if (abort) state_d = S_IDLE;
      else if (k_ready && round_q == LAST_IDX) state_d = S_IDLE;
    end
  end

  always_comb begin
    round_d  = round_q;
    k_d      = k_q;
    k_last_d = k_last_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        round_d  = '0;
        k_d      = k_word(0);
        k_last_d = 1'b0;
      end
    end else begin
      if (abort) begin
        k_last_d = 1'b0;
      end else if (k_ready) begin
        if (round_q == LAST_IDX) begin
          k_last_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          round_d  = round_q + 1'b1;
          k_d      = k_word(int'(round_q) + 1);
          k_last_d = (round_d == LAST_IDX);
        end
      end
    end
  end

  assign k       = k_q;
  assign round   = round_q;
  assign k_valid = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN);
  assign k_last  = k_last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// tb/tb_sha2_k_sequencer.sv - bench for sha2_k_sequencer, 32- and 64-bit instances side by side
// Shared stimulus drives both widths; a stream model and a transfer scoreboard check every cycle.
module tb_sha2_k_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, k_ready;
  logic [31:0] k32;
  logic [63:0] k64;
  logic [6:0]  rnd32, rnd64;
  logic        kv32, kv64, kl32, kl64, bz32, bz64, dn32, dn64;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sha2_k_sequencer #(.WORD_W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_ready(k_ready),
    .k(k32), .round(rnd32), .k_valid(kv32), .k_last(kl32), .busy(bz32), .done(dn32)
  );

  sha2_k_sequencer #(.WORD_W(64)) dut64 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_ready(k_ready),
    .k(k64), .round(rnd64), .k_valid(kv64), .k_last(kl64), .busy(bz64), .done(dn64)
  );

  logic [63:0] g [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic int rounds(int i);
    return (i == 0) ? 64 : 80;
  endfunction

  function automatic logic [63:0] gk(int i, int idx);
    logic [63:0] e;
    e = g[(idx > 79) ? 79 : idx];
    return (i == 0) ? {32'h0, e[63:32]} : e;
  endfunction

  function automatic logic [63:0] o_k(int i);   return (i == 0) ? {32'h0, k32} : k64; endfunction
  function automatic logic [63:0] o_rnd(int i); return (i == 0) ? 64'(rnd32) : 64'(rnd64); endfunction
  function automatic logic o_kv(int i); return (i == 0) ? kv32 : kv64; endfunction
  function automatic logic o_kl(int i); return (i == 0) ? kl32 : kl64; endfunction
  function automatic logic o_bz(int i); return (i == 0) ? bz32 : bz64; endfunction
  function automatic logic o_dn(int i); return (i == 0) ? dn32 : dn64; endfunction

  task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s w%0d: got 0x%0h expected 0x%0h", name, (i == 0) ? 32 : 64, act, exp);
    end
  endtask

  // Stream model: an "active" flag, an index into the table, and the word last presented.
  bit          m_act [2];
  int          m_idx [2];
  logic [63:0] m_k   [2];
  bit          m_done[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_idx[i] = 0; m_k[i] = '0; m_done[i] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          m_act[i] = 0; m_idx[i] = 0; m_k[i] = '0; m_done[i] = 0;
        end else begin
          m_done[i] = 0;
          if (m_act[i]) begin
            if (abort) m_act[i] = 0;
            else if (k_ready) begin
              if (m_idx[i] == rounds(i) - 1) begin
                m_act[i] = 0; m_done[i] = 1;
              end else begin
                m_idx[i] = m_idx[i] + 1;
                m_k[i]   = gk(i, m_idx[i]);
              end
            end
          end else if (start && !abort) begin
            m_act[i] = 1; m_idx[i] = 0; m_k[i] = gk(i, 0);
          end
        end
      end
    end
  end

  // Compare process: model check every cycle plus a transfer scoreboard per stream.
  initial begin
    bit          pv [2];
    logic [63:0] pr [2];
    logic [63:0] pk [2];
    int          cnt[2];
    for (int i = 0; i < 2; i++) begin pv[i] = 0; pr[i] = '0; pk[i] = '0; cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("k",       i, o_k(i),   m_k[i]);
        chk("round",   i, o_rnd(i), 64'(m_idx[i]));
        chk("k_valid", i, o_kv(i),  m_act[i]);
        chk("busy",    i, o_bz(i),  m_act[i]);
        chk("k_last",  i, o_kl(i),  m_act[i] && (m_idx[i] == rounds(i) - 1));
        chk("done",    i, o_dn(i),  m_done[i]);
        if (reset) cnt[i] = 0;
        else begin
          if (pv[i] && k_ready && !abort) begin
            chk("xfer_round", i, pr[i], 64'(cnt[i]));
            chk("xfer_k",     i, pk[i], gk(i, cnt[i]));
            cnt[i]++;
          end
          if (!pv[i] && o_kv(i)) cnt[i] = 0;
          if (o_dn(i)) chk("xfer_count", i, 64'(cnt[i]), 64'(rounds(i)));
        end
        pv[i] = o_kv(i); pr[i] = o_rnd(i); pk[i] = o_k(i);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic bit cond(int sel, int val);
    case (sel)
      0: return kv32 && (int'(rnd32) == val);
      1: return kv64 && (int'(rnd64) == val);
      2: return dn32;
      3: return dn64;
      default: return !bz32 && !bz64;
    endcase
  endfunction

  task automatic wait_for(string name, int sel, int val, int bound);
    int n = 0;
    while (!cond(sel, val) && n < bound) begin
      cyc();
      n++;
    end
    if (!cond(sel, val)) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, bound);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; k_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_k", 0, k32, 0);       chk("rst_k", 1, k64, 0);
    chk("rst_round", 0, rnd32, 0); chk("rst_round", 1, rnd64, 0);
    chk("rst_valid", 0, kv32, 0);  chk("rst_busy", 1, bz64, 0);
    reset = 1'b0;
    cyc();

    // full stream, consumer always ready
    start = 1'b1; k_ready = 1'b1;
    cyc();
    start = 1'b0;
    chk("k0", 0, k32, 64'h428a2f98);  chk("k0", 1, k64, 64'h428a2f98d728ae22);
    chk("r0", 0, rnd32, 0);           chk("v0", 1, kv64, 1);
    cyc();
    chk("k1", 0, k32, 64'h71374491);  chk("k1", 1, k64, 64'h7137449123ef65cd);
    wait_for("w_r63", 0, 63, 80);
    chk("k63", 0, k32, 64'hc67178f2); chk("last63", 0, kl32, 1);
    cyc();
    chk("done64th", 0, dn32, 1);      chk("valid_after", 0, kv32, 0);
    wait_for("w_r79", 1, 79, 40);
    chk("k79", 1, k64, 64'h6c44198c4a475817); chk("last79", 1, kl64, 1);
    cyc();
    chk("done80th", 1, dn64, 1);      chk("valid_after", 1, kv64, 0);

    // random backpressure
    cyc();
    start = 1'b1; k_ready = 1'($urandom_range(0, 1));
    cyc();
    start = 1'b0;
    for (int n = 0; n < 1000 && (bz32 || bz64); n++) begin
      k_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("bp_idle", 0, {bz32, bz64}, 0);

    // abort at round 17, then abort+start in IDLE, then restart
    k_ready = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_for("w_r17", 0, 17, 40);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ab_valid", i, o_kv(i), 0); chk("ab_busy", i, o_bz(i), 0); chk("ab_done", i, o_dn(i), 0);
    end
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_start_drop", 0, kv32, 0);
    cyc();
    start = 1'b0;
    chk("restart_r", 0, rnd32, 0); chk("restart_k", 0, k32, 64'h428a2f98);
    chk("restart_k", 1, k64, 64'h428a2f98d728ae22);
    wait_for("w_idle1", 4, 0, 200);

    // start during RUN ignored; start in the done cycle accepted
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_for("w_r5", 0, 5, 20);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_start_ign", 0, rnd32, 6);
    wait_for("w_done32", 2, 0, 100);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("b2b_r", 0, rnd32, 0); chk("b2b_v", 0, kv32, 1); chk("b2b_k", 0, k32, 64'h428a2f98);
    chk("busy_start_ign", 1, rnd64, 65);
    wait_for("w_idle2", 4, 0, 200);

    // asynchronous reset mid-stream, between clock edges
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_for("w_r30", 0, 30, 40);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_k", i, o_k(i), 0);       chk("arst_round", i, o_rnd(i), 0);
      chk("arst_valid", i, o_kv(i), 0);  chk("arst_last", i, o_kl(i), 0);
      chk("arst_busy", i, o_bz(i), 0);   chk("arst_done", i, o_dn(i), 0);
    end
    cyc();
    cyc();
    reset = 1'b0;
    repeat (4) cyc();
    chk("post_rst_idle", 0, kv32, 0); chk("post_rst_idle", 1, bz64, 0);

    // random mix of start/abort/ready
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 9) == 0);
      abort   = ($urandom_range(0, 29) == 0);
      k_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    start = 1'b0; abort = 1'b0; k_ready = 1'b1;
    wait_for("w_idle3", 4, 0, 200);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_k_sequencer.md
Name: sha2_k_sequencer

Overview:
- Parametrised round-constant source for the SHA-2 family.
- WORD_W=32 supplies the 64 SHA-224/256 constants; WORD_W=64 supplies the 80 SHA-384/512 constants.
- Unlike a plain address-indexed constant table, it owns the round counter. It streams K[t] in order over a valid/ready handshake, with registered output, stall support, abort, and a done pulse.
- Sits between the compression-round controller and the round datapath.

Parameters:
- WORD_W, 32, constant word width; legal values 32 or 64. Any other value is an elaboration error.
- ROUNDS, derived localparam (not overridable): 64 when WORD_W=32, 80 when WORD_W=64.
- RND_W, 7, width of the round index output; fixed, covers 0..79.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a constant stream; honoured only in IDLE.
- abort  in  1  synchronous cancel of the current stream.
- k_ready  in  1  consumer accepts the current constant.
- k  out  WORD_W  round constant K[round].
- round  out  RND_W  index of the constant on k.
- k_valid  out  1  k/round hold a valid constant.
- k_last  out  1  current constant is K[ROUNDS-1].
- busy  out  1  stream in progress (start not accepted).
- done  out  1  one-cycle pulse after the final constant is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; k=0, round=0, k_valid=0, k_last=0, busy=0, done=0.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: k_valid=0, busy=0.
  - RUN: k_valid=1, busy=1.
- IDLE:
  - start=1 -> next cycle RUN, round=0, k=K[0], k_valid=1, busy=1. Latency from start to first valid is 1 cycle.
  - While in IDLE, k holds its last value and round holds its last value.
- RUN, transfer = k_valid & k_ready:
  - Transfer with round<ROUNDS-1 -> next cycle round+1, k=K[round+1].
  - Transfer with round=ROUNDS-1 -> next cycle IDLE, k_valid=0, busy=0, done=1 for exactly one cycle.
  - No transfer (k_ready=0) -> k, round and k_last hold unchanged for any number of cycles.
  - A full stream with k_ready held high takes ROUNDS cycles of k_valid. done is asserted on cycle ROUNDS+1 after start.
- k_last = k_valid & (round==ROUNDS-1). It is registered together with k.
- start while busy=1 is ignored; the counter is not disturbed.
- start in the same cycle done=1 (state already IDLE) is accepted normally, so back-to-back streams are possible with one idle cycle between them.
- abort=1 in RUN -> next cycle IDLE, k_valid=0, busy=0, done stays 0. abort has priority over a simultaneous transfer.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is dropped.
- Reset mid-stream: immediate return to reset values. No done pulse is generated.
- Constant table:
  - FIPS 180-4 values, indexed 0..ROUNDS-1.
  - In 64-bit mode the upper 32 bits of K[0..63] equal the 32-bit table entries.
  - Indices >= ROUNDS are never presented. The lookup default returns 0.
- round never exceeds ROUNDS-1; there is no wrap-around to 0 within a stream.

Test Plan:
- WORD_W=32, reset then start pulse, k_ready=1: cycle+1 gives k=32'h428a2f98, round=0. Round 1 gives 32'h71374491. Round 63 gives 32'hc67178f2 with k_last=1. The next cycle gives done=1, k_valid=0. Exactly 64 transfers occur.
- WORD_W=64, same stimulus: K[0]=64'h428a2f98d728ae22, K[1]=64'h7137449123ef65cd, K[79]=64'h6c44198c4a475817 with k_last=1. Exactly 80 transfers, then a done pulse.
- Backpressure: k_ready toggled pseudo-randomly. k/round must stay stable while k_ready=0, no index may be skipped or repeated, and the collected stream must equal the golden table.
- Abort at round 17 with k_ready=1: the next cycle has k_valid=0, busy=0, done=0. A subsequent start restarts at round=0, K[0].
- start pulsed during RUN at round 5: stream unaffected, still 64 transfers. start asserted in the done cycle: a new stream begins with round=0 on the next cycle.
- Async reset asserted mid-clock at round 30: outputs go to 0 immediately without waiting for a clock edge. After release the block stays IDLE until start.
